adder_nbit: RTL and testbench

- Parameterised N-bit unsigned adder: sum = a + b, with carry-out.
- Operands are added combinationally through a ripple-carry chain of full-adder cells. The result is registered, so outputs update one clock after the operands are sampled.
- Leaf arithmetic block for datapath use. No handshake: every clock edge produces a result.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/full_adder_cell.sv | 20 ++
 rtl/adder_nbit.sv | 78 +++++++
 tb/tb_adder_nbit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg : shared constants and raw-result type for the adder_nbit slice.
// Revision  : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  localparam int ADDER_DEFAULT_N = 4;
  localparam int ADDER_MAX_N     = 64;

  // Widest (N+1)-bit raw result; narrower builds use the low N bits of sum.
  typedef struct packed {
    logic                   carry;
    logic [ADDER_MAX_N-1:0] sum;
  } adder_raw_t;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell : single-bit combinational full adder, one ripple stage.
// Revision        : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

`default_nettype wire

// File: rtl/adder_nbit.sv
// -----------------------------------------------------------------------------
// adder_nbit : N-bit unsigned ripple-carry adder with registered sum/carryout.
//              Optional registered signed-overflow flag under ADDER_OVERFLOW_EN.
// Revision   : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module adder_nbit
  import adder_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carryout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  logic [N:0]   carry_chain;
  logic [N-1:0] sum_d;
  logic [N-1:0] sum_q;
  logic         carry_d;
  logic         carry_q;

  assign carry_chain[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_chain
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_chain[i]),
      .s    (sum_d[i]),
      .cout (carry_chain[i+1])
    );
  end

  assign carry_d = carry_chain[N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum      = sum_q;
  assign carryout = carry_q;

`ifdef ADDER_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign ovf_d = (a[N-1] == b[N-1]) && (sum_d[N-1] != a[N-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule : adder_nbit

`default_nettype wire

// File: tb/tb_adder_nbit.sv
// -----------------------------------------------------------------------------
// tb_adder_nbit : self-checking bench for adder_nbit at N=4, N=1 and N=16.
// Revision      : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_adder_nbit;
  import adder_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  a4,  b4,  s4;
  logic [0:0]  a1,  b1,  s1;
  logic [15:0] a16, b16, s16;
  logic        c4, c1, c16;
`ifdef ADDER_OVERFLOW_EN
  logic        o4, o1, o16;
`endif

  int checks;
  int errors;

  adder_nbit #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .sum(s4), .carryout(c4)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(o4)
`endif
  );

  adder_nbit #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sum(s1), .carryout(c1)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(o1)
`endif
  );

  adder_nbit #(.N(16)) u_dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .sum(s16), .carryout(c16)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(o16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic, truncated to n bits.
  function automatic adder_raw_t ref_add(input logic [63:0] x, input logic [63:0] y, input int n);
    logic [64:0] full;
    logic [63:0] mask;
    adder_raw_t  r;
    full    = {1'b0, x} + {1'b0, y};
    mask    = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    r.sum   = full[63:0] & mask;
    r.carry = full[n];
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [63:0] x, input logic [63:0] y, input int n);
    adder_raw_t r;
    r = ref_add(x, y, n);
    return (x[n-1] == y[n-1]) && (r.sum[n-1] != x[n-1]);
  endfunction

  adder_raw_t e4, e1, e16;
  logic       eo4, eo1, eo16;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e4 <= '0; e1 <= '0; e16 <= '0;
      eo4 <= 1'b0; eo1 <= 1'b0; eo16 <= 1'b0;
    end else begin
      e4   <= ref_add(64'(a4),  64'(b4),  4);
      e1   <= ref_add(64'(a1),  64'(b1),  1);
      e16  <= ref_add(64'(a16), 64'(b16), 16);
      eo4  <= ref_ovf(64'(a4),  64'(b4),  4);
      eo1  <= ref_ovf(64'(a1),  64'(b1),  1);
      eo16 <= ref_ovf(64'(a16), 64'(b16), 16);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model on every falling edge.
  always @(negedge clk) begin
    if (checks < 100000) begin
      chk("n4.sum",    64'(s4),  e4.sum);
      chk("n4.carry",  64'(c4),  64'(e4.carry));
      chk("n1.sum",    64'(s1),  e1.sum);
      chk("n1.carry",  64'(c1),  64'(e1.carry));
      chk("n16.sum",   64'(s16), e16.sum);
      chk("n16.carry", 64'(c16), 64'(e16.carry));
`ifdef ADDER_OVERFLOW_EN
      chk("n4.ovf",  64'(o4),  64'(eo4));
      chk("n1.ovf",  64'(o1),  64'(eo1));
      chk("n16.ovf", 64'(o16), 64'(eo16));
`endif
    end
  end

  task automatic drive(input logic [3:0] x4, input logic [3:0] y4,
                       input logic x1, input logic y1,
                       input logic [15:0] x16, input logic [15:0] y16);
    @(negedge clk);
    #1;
    a4 = x4; b4 = y4; a1 = x1; b1 = y1; a16 = x16; b16 = y16;
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    a4 = 4'hF; b4 = 4'h1; a1 = 1'b1; b1 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001;
    #1 rst = 1'b1;

    // Reset held across several edges with nonzero operands.
    repeat (3) begin
      settle();
      chk("rst.sum4", 64'(s4), 64'h0);
      chk("rst.carry4", 64'(c4), 64'h0);
    end
    @(negedge clk);
    #1 rst = 1'b0;

    // Wrap boundaries with literal expectations.
    drive(4'hF, 4'h1, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
    settle();
    chk("wrap.F+1.sum", 64'(s4), 64'h0);
    chk("wrap.F+1.c",   64'(c4), 64'h1);
    chk("n16.FFFF+1.sum", 64'(s16), 64'h0);
    chk("n16.FFFF+1.c",   64'(c16), 64'h1);
    drive(4'hF, 4'hF, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    settle();
    chk("wrap.F+F.sum", 64'(s4), 64'hE);
    chk("wrap.F+F.c",   64'(c4), 64'h1);
    chk("n1.1+1.sum",   64'(s1), 64'h0);
    chk("n1.1+1.c",     64'(c1), 64'h1);
    chk("n16.max.sum",  64'(s16), 64'hFFFE);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    settle();
    chk("zero.sum", 64'(s4), 64'h0);
    chk("zero.c",   64'(c4), 64'h0);

    // Latency: outputs move only on the clock edge.
    drive(4'h3, 4'h2, 1'b0, 1'b1, 16'h1234, 16'h0002);
    settle();
    chk("lat.first", 64'(s4), 64'h5);
    drive(4'h5, 4'h2, 1'b1, 1'b0, 16'h1234, 16'h0004);
    chk("lat.hold", 64'(s4), 64'h5);
    settle();
    chk("lat.next", 64'(s4), 64'h7);

`ifdef ADDER_OVERFLOW_EN
    drive(4'h7, 4'h1, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    settle();
    chk("ovf.7+1.o", 64'(o4), 64'h1);
    chk("ovf.7+1.s", 64'(s4), 64'h8);
    chk("ovf.7+1.c", 64'(c4), 64'h0);
    chk("ovf.n16.o", 64'(o16), 64'h1);
    drive(4'h8, 4'h8, 1'b1, 1'b1, 16'h8000, 16'h8000);
    settle();
    chk("ovf.8+8.o", 64'(o4), 64'h1);
    chk("ovf.8+8.s", 64'(s4), 64'h0);
    chk("ovf.8+8.c", 64'(c4), 64'h1);
    chk("ovf.n1.o",  64'(o1), 64'h1);
    drive(4'hF, 4'h1, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    settle();
    chk("ovf.F+1.o", 64'(o4), 64'h0);
`endif

    // Exhaustive N=4 sweep, random/corner operands for N=1 and N=16.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(i);
      drive(ab[7:4], ab[3:0], 1'($urandom), 1'($urandom), pick16(), pick16());
    end

    // Asynchronous reset mid-cycle after a nonzero result.
    drive(4'h9, 4'h9, 1'b1, 1'b1, 16'hABCD, 16'h1111);
    settle();
    chk("pre.rst.sum4", 64'(s4), 64'h2);
    #2 rst = 1'b1;
    #1;
    chk("async.sum4",   64'(s4),  64'h0);
    chk("async.c4",     64'(c4),  64'h0);
    chk("async.sum16",  64'(s16), 64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    a4 = 4'h6; b4 = 4'h7;
    settle();
    chk("post.rst.sum4", 64'(s4), 64'hD);

    for (int i = 0; i < 40; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), pick16(), pick16());
    end

    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder_nbit

`default_nettype wire
